video_sync_v: RTL and testbench



---
 rtl/video_timing_pkg.sv | 40 ++++
 rtl/video_int_gen.sv | 55 +++++
 rtl/video_sync_v.sv | 100 ++++++++++
 tb/tb_video_sync_v.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared frame timing constants for the horizontal and vertical sync generators.
// Line numbers are 9-bit; INT length is counted in 7 MHz cend ticks.
package video_timing_pkg;

  localparam logic [1:0] RASTER_PENT0 = 2'b00;
  localparam logic [1:0] RASTER_PENT1 = 2'b01;
  localparam logic [1:0] RASTER_48K   = 2'b10;
  localparam logic [1:0] RASTER_128K  = 2'b11;

  localparam logic [8:0] LINES_PENT = 9'd320;
  localparam logic [8:0] LINES_48K  = 9'd312;
  localparam logic [8:0] LINES_128K = 9'd311;

  localparam logic [8:0] VBLNK_BEG     = 9'd0;
  localparam logic [8:0] VBLNK_END     = 9'd32;
  localparam logic [8:0] VSYNC_BEG     = 9'd8;
  localparam logic [8:0] VSYNC_END     = 9'd10;
  localparam logic [8:0] VPIX_BEG_PENT = 9'd80;
  localparam logic [8:0] VPIX_END_PENT = 9'd272;
  localparam logic [8:0] VPIX_BEG_ATM  = 9'd76;
  localparam logic [8:0] VPIX_END_ATM  = 9'd276;

  localparam logic [8:0] INT_LINE = 9'd0;
  localparam logic [6:0] INT_LEN  = 7'd64;

  typedef enum logic {
    INT_IDLE   = 1'b0,
    INT_ACTIVE = 1'b1
  } int_state_e;

  // Number of the final line of a frame for the given raster mode.
  function automatic logic [8:0] last_line(input logic [1:0] raster);
    case (raster)
      RASTER_48K:  last_line = LINES_48K - 9'd1;
      RASTER_128K: last_line = LINES_128K - 9'd1;
      default:     last_line = LINES_PENT - 9'd1;
    endcase
  endfunction

endpackage

// File: rtl/video_int_gen.sv
// Z80 maskable INT pulse: one trigger starts a pulse exactly INT_LEN cend ticks wide.
// Triggers arriving while the pulse is active are ignored.
module video_int_gen
  import video_timing_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cend,
  input  logic trigger,
  output logic int_start,
  output logic int_req
);

  int_state_e state_q;
  logic [6:0] cnt_q;
  logic       int_start_q;
  logic       int_req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INT_IDLE;
      cnt_q       <= 7'd0;
      int_start_q <= 1'b0;
      int_req_q   <= 1'b0;
    end else begin
      int_start_q <= 1'b0;
      case (state_q)
        INT_IDLE: begin
          if (trigger) begin
            state_q     <= INT_ACTIVE;
            cnt_q       <= INT_LEN - 7'd1;
            int_start_q <= 1'b1;
            int_req_q   <= 1'b1;
          end
        end
        INT_ACTIVE: begin
          // The cend seen with cnt_q == 0 is the INT_LEN-th tick of the pulse.
          if (cend) begin
            if (cnt_q == 7'd0) begin
              state_q   <= INT_IDLE;
              int_req_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 7'd1;
            end
          end
        end
        default: state_q <= INT_IDLE;
      endcase
    end
  end

  assign int_start = int_start_q;
  assign int_req   = int_req_q;

endmodule

// File: rtl/video_sync_v.sv
// Vertical frame scheduler: line counter, vertical blank/sync/pixel window decode
// and the frame-start strobe, plus the INT generator triggered on INT_LINE.
module video_sync_v
  import video_timing_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cend,
  input  logic       hsync_start,
  input  logic       line_start,
  input  logic       hint_start,
  input  logic [1:0] modes_raster,
  input  logic       mode_atm_n_pent,
  output logic [8:0] vcount,
  output logic       vblank,
  output logic       vsync,
  output logic       vpix,
  output logic       frame_start,
  output logic       int_start,
  output logic       int_req
);

  logic [8:0] vcount_q, vcount_d;
  logic       vblank_q, vblank_d;
  logic       vsync_q, vsync_d;
  logic       vpix_q, vpix_d;
  logic       frame_start_q, frame_start_d;
  logic [8:0] line_last;
  logic [8:0] vpix_beg;
  logic [8:0] vpix_end;
  logic       int_trigger;

  assign line_last = last_line(modes_raster);
  assign vpix_beg  = mode_atm_n_pent ? VPIX_BEG_ATM : VPIX_BEG_PENT;
  assign vpix_end  = mode_atm_n_pent ? VPIX_END_ATM : VPIX_END_PENT;

  always_comb begin
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    vblank_d      = vblank_q;
    vsync_d       = vsync_q;
    vpix_d        = vpix_q;

    // >= so that shrinking the frame mid-way wraps immediately instead of running to 511.
    if (hsync_start) begin
      if (vcount_q >= line_last) begin
        vcount_d      = 9'd0;
        frame_start_d = 1'b1;
      end else begin
        vcount_d = vcount_q + 9'd1;
      end
    end

    if (line_start) begin
      if (vcount_q == VBLNK_BEG)      vblank_d = 1'b1;
      else if (vcount_q == VBLNK_END) vblank_d = 1'b0;

      if (vcount_q == VSYNC_BEG)      vsync_d = 1'b1;
      else if (vcount_q == VSYNC_END) vsync_d = 1'b0;

      if (vcount_q == vpix_beg)       vpix_d = 1'b1;
      else if (vcount_q == vpix_end)  vpix_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vcount_q      <= 9'd0;
      vblank_q      <= 1'b0;
      vsync_q       <= 1'b0;
      vpix_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      vcount_q      <= vcount_d;
      vblank_q      <= vblank_d;
      vsync_q       <= vsync_d;
      vpix_q        <= vpix_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Compares the pre-increment line so a coincident hsync_start does not hide line 0.
  assign int_trigger = hint_start && (vcount_q == INT_LINE);

  video_int_gen u_int_gen (
    .clk       (clk),
    .rst       (rst),
    .cend      (cend),
    .trigger   (int_trigger),
    .int_start (int_start),
    .int_req   (int_req)
  );

  assign vcount      = vcount_q;
  assign vblank      = vblank_q;
  assign vsync       = vsync_q;
  assign vpix        = vpix_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_sync_v.sv
// Directed bench for video_sync_v: table of line/decode vectors plus hand-written
// sequences for frame length, mode switch, INT width, coincident strobes and reset.
module tb_video_sync_v;

  logic       clk = 1'b0;
  logic       rst;
  logic       cend, hsync_start, line_start, hint_start;
  logic [1:0] modes_raster;
  logic       mode_atm_n_pent;
  logic [8:0] vcount;
  logic       vblank, vsync, vpix, frame_start, int_start, int_req;

  int n_cmp = 0;
  int n_err = 0;

  video_sync_v dut (
    .clk             (clk),
    .rst             (rst),
    .cend            (cend),
    .hsync_start     (hsync_start),
    .line_start      (line_start),
    .hint_start      (hint_start),
    .modes_raster    (modes_raster),
    .mode_atm_n_pent (mode_atm_n_pent),
    .vcount          (vcount),
    .vblank          (vblank),
    .vsync           (vsync),
    .vpix            (vpix),
    .frame_start     (frame_start),
    .int_start       (int_start),
    .int_req         (int_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] raster;
    logic       atm;
    int         line;
    logic       vb;
    logic       vs;
    logic       vp;
    int         fs;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock with the given strobes; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic c, input logic hs, input logic ls, input logic hi);
    cend = c; hsync_start = hs; line_start = ls; hint_start = hi;
    @(posedge clk);
    #1;
    cend = 1'b0; hsync_start = 1'b0; line_start = 1'b0; hint_start = 1'b0;
  endtask

  task automatic next_line(output int fs);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    fs = int'(frame_start);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic advance_to(input int target, output int fs_cnt);
    int guard;
    int fs;
    guard  = 0;
    fs_cnt = 0;
    do begin
      next_line(fs);
      fs_cnt += fs;
      guard++;
    end while (int'(vcount) != target && guard < 1024);
    if (int'(vcount) != target) check("advance_to_timeout", int'(vcount), target);
  endtask

  // Counts hsync_start strobes up to and including the one producing frame_start.
  task automatic count_frame(output int n, output int maxv);
    n    = 0;
    maxv = 0;
    for (int i = 0; i < 1024; i++) begin
      if (int'(vcount) > maxv) maxv = int'(vcount);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
      if (frame_start) break;
    end
  endtask

  // Runs cend at half rate until int_req falls; width = cend ticks seen with int_req high.
  task automatic measure_int(input int extra_at, output int width, output int starts);
    logic c;
    logic req_b;
    width  = 0;
    starts = 0;
    for (int i = 0; i < 400 && int_req; i++) begin
      c     = (i % 2) == 1;
      req_b = int_req;
      cyc(c, 1'b0, 1'b0, i == extra_at);
      if (req_b && c) width++;
      if (int_start) starts++;
    end
    check("int_timeout_req", int'(int_req), 0);
  endtask

  initial begin
    int fs, n, maxv, width, starts;

    vecs[0]  = '{2'b00, 1'b0,   7, 1'b1, 1'b0, 1'b0, 0};
    vecs[1]  = '{2'b00, 1'b0,   8, 1'b1, 1'b1, 1'b0, 0};
    vecs[2]  = '{2'b00, 1'b0,   9, 1'b1, 1'b1, 1'b0, 0};
    vecs[3]  = '{2'b00, 1'b0,  10, 1'b1, 1'b0, 1'b0, 0};
    vecs[4]  = '{2'b00, 1'b0,  31, 1'b1, 1'b0, 1'b0, 0};
    vecs[5]  = '{2'b00, 1'b0,  32, 1'b0, 1'b0, 1'b0, 0};
    vecs[6]  = '{2'b00, 1'b0,  79, 1'b0, 1'b0, 1'b0, 0};
    vecs[7]  = '{2'b00, 1'b0,  80, 1'b0, 1'b0, 1'b1, 0};
    vecs[8]  = '{2'b00, 1'b0, 271, 1'b0, 1'b0, 1'b1, 0};
    vecs[9]  = '{2'b00, 1'b0, 272, 1'b0, 1'b0, 1'b0, 0};
    vecs[10] = '{2'b00, 1'b0, 319, 1'b0, 1'b0, 1'b0, 0};
    vecs[11] = '{2'b00, 1'b0,   0, 1'b1, 1'b0, 1'b0, 1};
    vecs[12] = '{2'b00, 1'b1,  75, 1'b0, 1'b0, 1'b0, 0};
    vecs[13] = '{2'b00, 1'b1,  76, 1'b0, 1'b0, 1'b1, 0};
    vecs[14] = '{2'b00, 1'b1, 275, 1'b0, 1'b0, 1'b1, 0};
    vecs[15] = '{2'b00, 1'b1, 276, 1'b0, 1'b0, 1'b0, 0};
    vecs[16] = '{2'b00, 1'b1,   0, 1'b1, 1'b0, 1'b0, 1};

    rst = 1'b1;
    cend = 1'b0; hsync_start = 1'b0; line_start = 1'b0; hint_start = 1'b0;
    modes_raster = 2'b00;
    mode_atm_n_pent = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vcount", int'(vcount), 0);
    check("rst_vblank", int'(vblank), 0);
    check("rst_int_req", int'(int_req), 0);
    rst = 1'b0;

    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_frame_start", int'(frame_start), 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("line0_vblank", int'(vblank), 1);

    foreach (vecs[i]) begin
      modes_raster    = vecs[i].raster;
      mode_atm_n_pent = vecs[i].atm;
      advance_to(vecs[i].line, fs);
      $display("vec %0d line %0d: vblank %0b vsync %0b vpix %0b fs %0d",
               i, vcount, vblank, vsync, vpix, fs);
      check($sformatf("vec%0d_vblank", i), int'(vblank), int'(vecs[i].vb));
      check($sformatf("vec%0d_vsync", i), int'(vsync), int'(vecs[i].vs));
      check($sformatf("vec%0d_vpix", i), int'(vpix), int'(vecs[i].vp));
      check($sformatf("vec%0d_fs", i), fs, vecs[i].fs);
    end
    mode_atm_n_pent = 1'b0;

    // Frame lengths: two pentagon frames, then 48k and 128k.
    for (int f = 0; f < 2; f++) begin
      count_frame(n, maxv);
      $display("pent frame %0d: %0d strobes, last line %0d", f, n, maxv);
      check("pent_frame_len", n, 320);
      check("pent_last_line", maxv, 319);
      check("pent_wrap_vcount", int'(vcount), 0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("frame_start_one_clk", int'(frame_start), 0);

    modes_raster = 2'b10;
    count_frame(n, maxv);
    $display("48k frame: %0d strobes, last line %0d", n, maxv);
    check("48k_frame_len", n, 312);
    check("48k_last_line", maxv, 311);

    modes_raster = 2'b11;
    count_frame(n, maxv);
    $display("128k frame: %0d strobes, last line %0d", n, maxv);
    check("128k_frame_len", n, 311);
    check("128k_last_line", maxv, 310);

    // Shrinking the frame past the current line wraps at the next strobe.
    modes_raster = 2'b00;
    advance_to(315, fs);
    modes_raster = 2'b11;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    $display("mode switch at 315: vcount %0d frame_start %0b", vcount, frame_start);
    check("switch_vcount", int'(vcount), 0);
    check("switch_frame_start", int'(frame_start), 1);
    modes_raster = 2'b00;

    // INT on line 0 with a retrigger attempt in the middle of the pulse.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("int_start_pulse", int'(int_start), 1);
    check("int_req_rise", int'(int_req), 1);
    measure_int(40, width, starts);
    $display("int with retrigger: width %0d extra starts %0d", width, starts);
    check("int_width", width, 64);
    check("int_no_retrigger", starts, 0);

    // hint_start coincident with hsync_start on line 0.
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    $display("coincident strobes: vcount %0d int_start %0b", vcount, int_start);
    check("coinc_vcount", int'(vcount), 1);
    check("coinc_int_start", int'(int_start), 1);
    measure_int(-1, width, starts);
    check("coinc_int_width", width, 64);

    // Reset mid-frame with INT active; lines advanced without cend so INT is still high.
    advance_to(0, fs);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 150; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("pre_rst_vcount", int'(vcount), 150);
    check("pre_rst_int_req", int'(int_req), 1);
    #2 rst = 1'b1;
    #1;
    $display("async reset: vcount %0d int_req %0b vblank %0b", vcount, int_req, vblank);
    check("arst_vcount", int'(vcount), 0);
    check("arst_int_req", int'(int_req), 0);
    check("arst_vblank", int'(vblank), 0);
    check("arst_vsync", int'(vsync), 0);
    check("arst_vpix", int'(vpix), 0);
    check("arst_flags", int'({frame_start, int_start}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    count_frame(n, maxv);
    $display("post reset frame: %0d strobes", n);
    check("post_rst_frame_len", n, 320);
    check("post_rst_int_req", int'(int_req), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
